apb_master_ctrl: RTL and testbench

APB_MASTER_CTRL -- requirements
Module: apb_master_ctrl

---
 rtl/apb_master_ctrl.sv | 111 +++++++++++
 tb/tb_apb_master_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master_ctrl.sv
// APB master controller: sequences processor requests through IDLE/SETUP/ACCESS.
// Define APB_MASTER_CTRL_TIMEOUT_EN to abort ACCESS after wait_cycles+TIMEOUT_MARGIN cycles.
module apb_master_ctrl #(
   parameter int unsigned TIMEOUT_MARGIN = 4
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic       write,
   input  logic [1:0] sel,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   input  logic [7:0] wait_cycles,
   output logic [7:0] rdata,
   output logic       stable,
   output logic       busy,
   output logic       error,
   output logic       apb_write,
   output logic [1:0] apb_sel,
   output logic [7:0] apb_addr,
   output logic [7:0] apb_wdata,
   output logic       apb_enable,
   output logic [7:0] apb_wait_cycles,
   input  logic       apb_ready,
   input  logic [7:0] apb_rdata
);

`ifdef APB_MASTER_CTRL_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t     state;
   logic [8:0] count;
   logic [8:0] limit;
   logic       timed_out;
   logic       accept;
   logic       load;

   always_comb begin
      limit     = {1'b0, apb_wait_cycles} + 9'(TIMEOUT_MARGIN);
      // count+1 compared at 10 bits so the last ACCESS cycle is detected without wrap
      timed_out = TIMEOUT_EN && (({1'b0, count} + 10'd1) >= {1'b0, limit});
      accept    = start && (sel != 2'b00);
      load      = accept && ((state == IDLE) || ((state == ACCESS) && apb_ready));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         count           <= '0;
         rdata           <= '0;
         stable          <= 1'b0;
         busy            <= 1'b0;
         error           <= 1'b0;
         apb_write       <= 1'b0;
         apb_sel         <= '0;
         apb_addr        <= '0;
         apb_wdata       <= '0;
         apb_enable      <= 1'b0;
         apb_wait_cycles <= '0;
      end else begin
         stable <= 1'b0;
         error  <= 1'b0;
         case (state)
            IDLE: begin
               if (start && !accept) error <= 1'b1;
            end
            SETUP: begin
               state      <= ACCESS;
               apb_enable <= 1'b1;
               count      <= '0;
            end
            ACCESS: begin
               if (apb_ready) begin
                  if (!apb_write) rdata <= apb_rdata;
                  stable     <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
                  apb_sel    <= '0;
                  apb_enable <= 1'b0;
               end else if (timed_out) begin
                  error      <= 1'b1;
                  state      <= IDLE;
                  busy       <= 1'b0;
                  apb_sel    <= '0;
                  apb_enable <= 1'b0;
               end else if (count != '1) begin
                  count <= count + 9'd1;
               end
            end
            default: state <= IDLE;
         endcase
         // A request taken on a completing edge overrides the return to IDLE.
         if (load) begin
            state           <= SETUP;
            busy            <= 1'b1;
            apb_enable      <= 1'b0;
            apb_write       <= write;
            apb_sel         <= sel;
            apb_addr        <= addr;
            apb_wdata       <= wdata;
            apb_wait_cycles <= wait_cycles;
         end
      end
   end

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Testbench for apb_master_ctrl: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level model.
module tb_apb_master_ctrl;

   localparam int MARGIN = 4;
`ifdef APB_MASTER_CTRL_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       write = 1'b0;
   logic [1:0] sel = '0;
   logic [7:0] addr = '0, wdata = '0, wait_cycles = '0;
   logic       apb_ready = 1'b0;
   logic [7:0] apb_rdata = '0;
   logic [7:0] rdata;
   logic       stable, busy, error;
   logic       apb_write, apb_enable;
   logic [1:0] apb_sel;
   logic [7:0] apb_addr, apb_wdata, apb_wait_cycles;

   int checks = 0;
   int errors = 0;

   apb_master_ctrl #(.TIMEOUT_MARGIN(MARGIN)) dut (
      .clk(clk), .reset(reset), .start(start), .write(write), .sel(sel),
      .addr(addr), .wdata(wdata), .wait_cycles(wait_cycles), .rdata(rdata),
      .stable(stable), .busy(busy), .error(error), .apb_write(apb_write),
      .apb_sel(apb_sel), .apb_addr(apb_addr), .apb_wdata(apb_wdata),
      .apb_enable(apb_enable), .apb_wait_cycles(apb_wait_cycles),
      .apb_ready(apb_ready), .apb_rdata(apb_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 none, 1 address phase, 2 data phase; waited = data-phase cycles seen.
   int         m_phase = 0, m_waited = 0;
   bit         m_was_idle, m_done;
   logic       t_write = 0;
   logic [1:0] t_sel = 0;
   logic [7:0] t_addr = 0, t_wdata = 0, t_wait = 0, e_rdata = 0;
   logic       e_stable = 0, e_error = 0;

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         m_phase = 0; m_waited = 0; t_write = 0; t_sel = 0; t_addr = 0;
         t_wdata = 0; t_wait = 0; e_rdata = 0; e_stable = 0; e_error = 0;
      end else begin
         m_was_idle = (m_phase == 0);
         m_done = 0;
         e_stable = 0;
         e_error = 0;
         if (m_phase == 0) begin
            if (start && sel == 2'b00) e_error = 1;
         end else if (m_phase == 1) begin
            m_phase = 2;
            m_waited = 0;
         end else if (apb_ready) begin
            if (!t_write) e_rdata = apb_rdata;
            e_stable = 1;
            m_done = 1;
            m_phase = 0;
         end else begin
            m_waited++;
            if (TO_EN && m_waited >= int'(t_wait) + MARGIN) begin
               e_error = 1;
               m_phase = 0;
            end
         end
         if (start && sel != 2'b00 && (m_was_idle || m_done)) begin
            t_write = write; t_sel = sel; t_addr = addr; t_wdata = wdata; t_wait = wait_cycles;
            m_phase = 1;
         end
      end
   end

   always @(negedge clk) begin
      chk("m_busy", busy, m_phase != 0);
      chk("m_enable", apb_enable, m_phase == 2);
      chk("m_sel", apb_sel, (m_phase != 0) ? t_sel : 2'b00);
      chk("m_write", apb_write, t_write);
      chk("m_addr", apb_addr, t_addr);
      chk("m_wdata", apb_wdata, t_wdata);
      chk("m_wait", apb_wait_cycles, t_wait);
      chk("m_rdata", rdata, e_rdata);
      chk("m_stable", stable, e_stable);
      chk("m_error", error, e_error);
      chk("m_excl", stable && error, 1'b0);
   end

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic req(input logic w, input logic [1:0] s, input logic [7:0] a,
                      input logic [7:0] d, input logic [7:0] wc);
      start = 1; write = w; sel = s; addr = a; wdata = d; wait_cycles = wc;
   endtask

   int cnt;

   initial begin
      #1 reset = 0;
      @(negedge clk);
      step();
      chk("rst_busy", busy, 0);
      chk("rst_rdata", rdata, 8'h00);
      reset = 1;
      step();

      // Read, ready high: SETUP, ACCESS, stable at start+3
      req(0, 2'b01, 8'h10, 8'h00, 8'h00);
      apb_ready = 1; apb_rdata = 8'hA5;
      step(); start = 0;
      chk("A_setup_busy", busy, 1);
      chk("A_setup_en", apb_enable, 0);
      chk("A_setup_sel", apb_sel, 2'b01);
      chk("A_setup_addr", apb_addr, 8'h10);
      step();
      chk("A_access_en", apb_enable, 1);
      chk("A_access_stable", stable, 0);
      step();
      chk("A_stable", stable, 1);
      chk("A_rdata", rdata, 8'hA5);
      chk("A_idle_busy", busy, 0);
      step();
      chk("A_stable_pulse", stable, 0);

      // Write, ready held low for 3 ACCESS cycles
      req(1, 2'b10, 8'h20, 8'h3C, 8'h03);
      apb_ready = 0; apb_rdata = 8'h77;
      step(); start = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("B_en", apb_enable, 1);
         chk("B_wdata", apb_wdata, 8'h3C);
         chk("B_nostable", stable, 0);
      end
      apb_ready = 1;
      step();
      chk("B_stable", stable, 1);
      chk("B_rdata_kept", rdata, 8'hA5);
      step();
      chk("B_stable_pulse", stable, 0);

      // Start with no slave selected
      req(0, 2'b00, 8'h30, 8'h00, 8'h00);
      step(); start = 0;
      chk("C_error", error, 1);
      chk("C_busy", busy, 0);
      chk("C_sel", apb_sel, 2'b00);
      step();
      chk("C_error_pulse", error, 0);

      // Back-to-back reads
      req(0, 2'b01, 8'h01, 8'h00, 8'h00);
      apb_ready = 1; apb_rdata = 8'h11;
      step(); start = 0;
      step();
      req(0, 2'b01, 8'h02, 8'h00, 8'h00);
      step(); start = 0; apb_rdata = 8'h22;
      chk("D_stable1", stable, 1);
      chk("D_rdata1", rdata, 8'h11);
      chk("D_busy", busy, 1);
      chk("D_setup_en", apb_enable, 0);
      chk("D_addr2", apb_addr, 8'h02);
      step();
      chk("D_access2", apb_enable, 1);
      step();
      chk("D_stable2", stable, 1);
      chk("D_rdata2", rdata, 8'h22);

      // Reset during ACCESS
      req(0, 2'b11, 8'h40, 8'h00, 8'h01);
      apb_ready = 0;
      step(); start = 0;
      step();
      chk("E_access", apb_enable, 1);
      #2 reset = 0;
      #1;
      chk("E_busy", busy, 0);
      chk("E_en", apb_enable, 0);
      chk("E_sel", apb_sel, 0);
      chk("E_addr", apb_addr, 0);
      chk("E_rdata", rdata, 0);
      chk("E_stable", stable, 0);
      chk("E_error", error, 0);
      @(negedge clk);
      reset = 1;
      step();
      chk("E_no_stable", stable, 0);
      req(0, 2'b01, 8'h55, 8'h00, 8'h00);
      apb_ready = 1; apb_rdata = 8'h5A;
      step(); start = 0;
      step();
      step();
      chk("E2_stable", stable, 1);
      chk("E2_rdata", rdata, 8'h5A);
      step();

      if (TO_EN) begin
         req(0, 2'b01, 8'h66, 8'h00, 8'h02);
         apb_ready = 0;
         step(); start = 0;
         cnt = 0;
         for (int i = 0; i < 20; i++) begin
            step();
            if (error) break;
            if (apb_enable) cnt++;
         end
         chk("T_error", error, 1);
         chk("T_cycles", cnt, 6);
         chk("T_busy", busy, 0);
         chk("T_stable", stable, 0);
         step();
      end

      // Randomized traffic
      for (int i = 0; i < 3000; i++) begin
         start       = ($urandom_range(0, 3) == 0);
         write       = 1'($urandom);
         sel         = 2'($urandom_range(0, 3));
         addr        = 8'($urandom);
         wdata       = 8'($urandom);
         wait_cycles = 8'($urandom_range(0, 6));
         apb_ready   = ($urandom_range(0, 2) != 0) || ($urandom_range(0, 9) == 0 && !TO_EN);
         apb_rdata   = 8'($urandom);
         if ($urandom_range(0, 199) == 0) begin
            #3 reset = 0;
            @(negedge clk);
            reset = 1;
         end
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
